noc_local_port: RTL and testbench

NOC_LOCAL_PORT -- requirements
Module: noc_local_port

---
 rtl/noc_local_port.sv | 174 +++++++++++++++++
 tb/tb_noc_local_port.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_port.sv
// ---------------------------------------------------------------------------
// noc_local_port
//
// Local (PE) port of a mesh NoC router.
//   - Injection: PE packets go into a first-word-fall-through FIFO and are
//     presented to the router local input with a valid/ready handshake.
//   - Ejection: router local-output packets are registered toward the PE
//     (valid-only, the PE always accepts).
//   - Statistics (optional): injection/ejection counters plus misroute
//     detection, enabled by defining NOC_LOCAL_PORT_STATS_EN. Without the
//     macro, the statistics outputs are tied to 0.
//
// Packet format: {dest_y[Y_SIZE], dest_x[X_SIZE], payload[DATA_WIDTH]}
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   pe_valid/pe_data/pe_ready  PE injection handshake
//   noc_valid/noc_data/noc_ready  router local-input handshake
//   ej_valid/ej_data           router local-output packet
//   pe_ej_valid/pe_ej_data     registered ejected packet toward the PE
//   inj_count, ej_count        packets accepted / delivered (wrap 2^32)
//   misroute_count             misrouted ejections (saturating)
//   misroute_err               sticky misroute flag
// ---------------------------------------------------------------------------
module noc_local_port #(
    parameter int XCORD       = 0,
    parameter int YCORD       = 0,
    parameter int X_SIZE      = 1,
    parameter int Y_SIZE      = 1,
    parameter int DATA_WIDTH  = 256,
    parameter int TOTAL_WIDTH = X_SIZE + Y_SIZE + DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pe_valid,
    input  logic [TOTAL_WIDTH-1:0] pe_data,
    output logic                   pe_ready,
    output logic                   noc_valid,
    output logic [TOTAL_WIDTH-1:0] noc_data,
    input  logic                   noc_ready,
    input  logic                   ej_valid,
    input  logic [TOTAL_WIDTH-1:0] ej_data,
    output logic                   pe_ej_valid,
    output logic [TOTAL_WIDTH-1:0] pe_ej_data,
    output logic [31:0]            inj_count,
    output logic [31:0]            ej_count,
    output logic [15:0]            misroute_count,
    output logic                   misroute_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

    // Elaboration-time configuration checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("noc_local_port: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TOTAL_WIDTH != X_SIZE + Y_SIZE + DATA_WIDTH) begin : g_bad_width
        $error("noc_local_port: TOTAL_WIDTH must equal X_SIZE+Y_SIZE+DATA_WIDTH");
    end
    if (XCORD < 0 || XCORD >= (1 << X_SIZE) || YCORD < 0 || YCORD >= (1 << Y_SIZE)) begin : g_bad_coord
        $error("noc_local_port: XCORD/YCORD do not fit the destination fields");
    end

    // ---------------- injection FIFO ----------------
    logic [TOTAL_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;
    logic [AW:0]            w_count_next;
    logic                   r_pe_ready;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_empty;

    assign w_not_empty = (r_count != '0);
    assign w_push      = pe_valid && r_pe_ready;
    assign w_pop       = w_not_empty && noc_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_pe_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_next;
            // Ready reflects occupancy after this edge's push and pop
            r_pe_ready <= (w_count_next != LP_DEPTH);
        end
    end

    // Storage needs no reset: empty entries are never presented
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= pe_data;
    end

    assign pe_ready  = r_pe_ready;
    assign noc_valid = w_not_empty;
    // Masked when empty so noc_data reads 0 in and after reset
    assign noc_data  = w_not_empty ? r_mem[r_rptr] : '0;

    // ---------------- ejection path ----------------
    logic                   r_pe_ej_valid;
    logic [TOTAL_WIDTH-1:0] r_pe_ej_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pe_ej_valid <= 1'b0;
            r_pe_ej_data  <= '0;
        end else begin
            r_pe_ej_valid <= ej_valid;
            if (ej_valid) r_pe_ej_data <= ej_data;
        end
    end

    assign pe_ej_valid = r_pe_ej_valid;
    assign pe_ej_data  = r_pe_ej_data;

    // ---------------- statistics ----------------
`ifdef NOC_LOCAL_PORT_STATS_EN
    localparam logic [X_SIZE-1:0] LP_XCORD = X_SIZE'(XCORD);
    localparam logic [Y_SIZE-1:0] LP_YCORD = Y_SIZE'(YCORD);

    logic [31:0] r_inj_count;
    logic [31:0] r_ej_count;
    logic [15:0] r_mis_count;
    logic        r_mis_err;
    logic        w_misroute;

    assign w_misroute = ej_valid &&
                        ((ej_data[DATA_WIDTH +: X_SIZE] != LP_XCORD) ||
                         (ej_data[DATA_WIDTH + X_SIZE +: Y_SIZE] != LP_YCORD));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inj_count <= '0;
            r_ej_count  <= '0;
            r_mis_count <= '0;
            r_mis_err   <= 1'b0;
        end else begin
            if (w_push)   r_inj_count <= r_inj_count + 1'b1;
            if (ej_valid) r_ej_count  <= r_ej_count + 1'b1;
            if (w_misroute) begin
                if (r_mis_count != '1) r_mis_count <= r_mis_count + 1'b1;
                r_mis_err <= 1'b1;
            end
        end
    end

    assign inj_count      = r_inj_count;
    assign ej_count       = r_ej_count;
    assign misroute_count = r_mis_count;
    assign misroute_err   = r_mis_err;
`else
    assign inj_count      = '0;
    assign ej_count       = '0;
    assign misroute_count = '0;
    assign misroute_err   = 1'b0;
`endif

endmodule

// File: tb/tb_noc_local_port.sv
// ---------------------------------------------------------------------------
// tb_noc_local_port
//
// Directed, table-driven bench for noc_local_port (XCORD=1, YCORD=0,
// X_SIZE=2, Y_SIZE=2, DATA_WIDTH=8, FIFO_DEPTH=4). Statistics expectations
// collapse to 0 when NOC_LOCAL_PORT_STATS_EN is not defined.
// ---------------------------------------------------------------------------
module tb_noc_local_port;

    localparam int TW = 12;
`ifdef NOC_LOCAL_PORT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          pe_valid;
    logic [TW-1:0] pe_data;
    logic          pe_ready;
    logic          noc_valid;
    logic [TW-1:0] noc_data;
    logic          noc_ready;
    logic          ej_valid;
    logic [TW-1:0] ej_data;
    logic          pe_ej_valid;
    logic [TW-1:0] pe_ej_data;
    logic [31:0]   inj_count;
    logic [31:0]   ej_count;
    logic [15:0]   misroute_count;
    logic          misroute_err;

    int n_checks = 0;
    int n_errors = 0;

    noc_local_port #(
        .XCORD      (1),
        .YCORD      (0),
        .X_SIZE     (2),
        .Y_SIZE     (2),
        .DATA_WIDTH (8),
        .TOTAL_WIDTH(TW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pe_valid      (pe_valid),
        .pe_data       (pe_data),
        .pe_ready      (pe_ready),
        .noc_valid     (noc_valid),
        .noc_data      (noc_data),
        .noc_ready     (noc_ready),
        .ej_valid      (ej_valid),
        .ej_data       (ej_data),
        .pe_ej_valid   (pe_ej_valid),
        .pe_ej_data    (pe_ej_data),
        .inj_count     (inj_count),
        .ej_count      (ej_count),
        .misroute_count(misroute_count),
        .misroute_err  (misroute_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          pv;
        logic [TW-1:0] pd;
        logic          nr;
        logic          ev;
        logic [TW-1:0] ed;
        logic          x_rdy;
        logic          x_nv;
        logic [TW-1:0] x_nd;
        logic          x_ejv;
        logic [TW-1:0] x_ejd;
        logic [31:0]   x_inj;
        logic [31:0]   x_ej;
        logic [31:0]   x_mis;
        logic          x_err;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic pv, input logic [TW-1:0] pd, input logic nr,
        input logic ev, input logic [TW-1:0] ed,
        input logic x_rdy, input logic x_nv, input logic [TW-1:0] x_nd,
        input logic x_ejv, input logic [TW-1:0] x_ejd,
        input logic [31:0] x_inj, input logic [31:0] x_ej,
        input logic [31:0] x_mis, input logic x_err);
        vec_t v;
        v.pv = pv; v.pd = pd; v.nr = nr; v.ev = ev; v.ed = ed;
        v.x_rdy = x_rdy; v.x_nv = x_nv; v.x_nd = x_nd;
        v.x_ejv = x_ejv; v.x_ejd = x_ejd;
        v.x_inj = x_inj; v.x_ej = x_ej; v.x_mis = x_mis; v.x_err = x_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] st(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic check_stats(input string tag, input logic [31:0] inj, input logic [31:0] ej,
                               input logic [31:0] mis, input logic err);
        check({tag, ".inj_count"}, inj_count, st(inj));
        check({tag, ".ej_count"}, ej_count, st(ej));
        check({tag, ".misroute_count"}, {16'd0, misroute_count}, st(mis));
        check({tag, ".misroute_err"}, {31'd0, misroute_err}, st({31'd0, err}));
    endtask

    initial begin
        // {pv, pd, nr, ev, ed, rdy, nv, nd, ejv, ejd, inj, ej, mis, err}
        // Fill with noc_ready=0: 5 pushes, 5th refused
        vecs[0]  = mk(1, 12'h001, 0, 0, 12'h000, 1, 1, 12'h001, 0, 12'h000, 1, 0, 0, 0);
        vecs[1]  = mk(1, 12'h002, 0, 0, 12'h000, 1, 1, 12'h001, 0, 12'h000, 2, 0, 0, 0);
        vecs[2]  = mk(1, 12'h003, 0, 0, 12'h000, 1, 1, 12'h001, 0, 12'h000, 3, 0, 0, 0);
        vecs[3]  = mk(1, 12'h004, 0, 0, 12'h000, 0, 1, 12'h001, 0, 12'h000, 4, 0, 0, 0);
        vecs[4]  = mk(1, 12'h005, 0, 0, 12'h000, 0, 1, 12'h001, 0, 12'h000, 4, 0, 0, 0);
        // Drain: head advances 2,3,4, then empty
        vecs[5]  = mk(0, 12'h000, 1, 0, 12'h000, 1, 1, 12'h002, 0, 12'h000, 4, 0, 0, 0);
        vecs[6]  = mk(0, 12'h000, 1, 0, 12'h000, 1, 1, 12'h003, 0, 12'h000, 4, 0, 0, 0);
        vecs[7]  = mk(0, 12'h000, 1, 0, 12'h000, 1, 1, 12'h004, 0, 12'h000, 4, 0, 0, 0);
        vecs[8]  = mk(0, 12'h000, 1, 0, 12'h000, 1, 0, 12'h000, 0, 12'h000, 4, 0, 0, 0);
        // Eject to (1,0) = this node, then (0,1) = misroute, then idle
        vecs[9]  = mk(0, 12'h000, 0, 1, 12'h1A5, 1, 0, 12'h000, 1, 12'h1A5, 4, 1, 0, 0);
        vecs[10] = mk(0, 12'h000, 0, 1, 12'h43C, 1, 0, 12'h000, 1, 12'h43C, 4, 2, 1, 1);
        vecs[11] = mk(0, 12'h000, 0, 0, 12'hFFF, 1, 0, 12'h000, 0, 12'h43C, 4, 2, 1, 1);

        rstn = 1'b1; pe_valid = 1'b0; pe_data = '0; noc_ready = 1'b0;
        ej_valid = 1'b0; ej_data = '0;
        #3 rstn = 1'b0;
        #14;
        // Reset state
        check("rst.pe_ready", {31'd0, pe_ready}, 32'd0);
        check("rst.noc_valid", {31'd0, noc_valid}, 32'd0);
        check("rst.noc_data", {20'd0, noc_data}, 32'd0);
        check("rst.pe_ej_valid", {31'd0, pe_ej_valid}, 32'd0);
        check("rst.pe_ej_data", {20'd0, pe_ej_data}, 32'd0);
        check_stats("rst", 0, 0, 0, 1'b0);

        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        check("rel.pe_ready", {31'd0, pe_ready}, 32'd1);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            pe_valid = vecs[i].pv; pe_data = vecs[i].pd; noc_ready = vecs[i].nr;
            ej_valid = vecs[i].ev; ej_data = vecs[i].ed;
            @(posedge clk) #1;
            check($sformatf("v%0d.pe_ready", i), {31'd0, pe_ready}, {31'd0, vecs[i].x_rdy});
            check($sformatf("v%0d.noc_valid", i), {31'd0, noc_valid}, {31'd0, vecs[i].x_nv});
            check($sformatf("v%0d.noc_data", i), {20'd0, noc_data}, {20'd0, vecs[i].x_nd});
            check($sformatf("v%0d.pe_ej_valid", i), {31'd0, pe_ej_valid}, {31'd0, vecs[i].x_ejv});
            check($sformatf("v%0d.pe_ej_data", i), {20'd0, pe_ej_data}, {20'd0, vecs[i].x_ejd});
            check_stats($sformatf("v%0d", i), vecs[i].x_inj, vecs[i].x_ej, vecs[i].x_mis, vecs[i].x_err);
        end
        ej_valid = 1'b0;

        // Streaming across pointer wrap: occupancy stays at 1, no bubbles
        for (int i = 0; i < 10; i++) begin
            pe_valid = 1'b1; pe_data = TW'(12'h010 + i); noc_ready = 1'b1;
            @(posedge clk) #1;
            check($sformatf("wrap%0d.noc_valid", i), {31'd0, noc_valid}, 32'd1);
            check($sformatf("wrap%0d.noc_data", i), {20'd0, noc_data}, 32'h10 + 32'(i));
            check($sformatf("wrap%0d.pe_ready", i), {31'd0, pe_ready}, 32'd1);
        end
        pe_valid = 1'b0;
        @(posedge clk) #1;
        check("wrap.end.noc_valid", {31'd0, noc_valid}, 32'd0);
        check("wrap.end.inj_count", inj_count, st(32'd14));

        // Reset mid-operation with 3 packets queued and an ejection in flight
        noc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pe_valid = 1'b1; pe_data = TW'(12'h020 + i);
            ej_valid = (i == 2); ej_data = 12'h1A5;
            @(posedge clk) #1;
        end
        pe_valid = 1'b0; ej_valid = 1'b0;
        check("mid.noc_valid", {31'd0, noc_valid}, 32'd1);
        check("mid.noc_data", {20'd0, noc_data}, 32'h020);
        check("mid.pe_ej_valid", {31'd0, pe_ej_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        check("mrst.noc_valid", {31'd0, noc_valid}, 32'd0);
        check("mrst.noc_data", {20'd0, noc_data}, 32'd0);
        check("mrst.pe_ready", {31'd0, pe_ready}, 32'd0);
        check("mrst.pe_ej_valid", {31'd0, pe_ej_valid}, 32'd0);
        check("mrst.pe_ej_data", {20'd0, pe_ej_data}, 32'd0);
        check_stats("mrst", 0, 0, 0, 1'b0);
        @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk) #1;
        check("mrel.pe_ready", {31'd0, pe_ready}, 32'd1);
        check("mrel.noc_valid", {31'd0, noc_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
